mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Parametrised successor of the MEM pipeline stage: pointer file plus a multi-cycle load/store engine.
// - Handles memories with wait states via a req/ack handshake and stalls the pipeline while busy.
// - Adds post-increment/pre-decrement addressing, write-back bypass into the pointer file and a bus timeout.
// - Sits between the EX/MEM register and the MEM/WB register; the load result feeds the MEM/WB data mux.
// PARAMETERS
// - DATA_W     8      memory data width
// - ADDR_W     16     pointer / address width
// - NUM_PTRS   4      pointer registers; index NUM_PTRS-1 is the stack pointer
// - TAG_W      5      destination register tag carried with a load
// - TIMEOUT    255    max BUSY cycles without mem_ack before abort (>=1)
// - STK_RESET  {ADDR_W{1'b1}}  stack pointer reset value
// PORTS
// - clock        in   1                clock, rising edge
// - nreset       in   1                asynchronous active-low reset
// - op_valid     in   1                memory op present in EX/MEM
// - op_store     in   1                1 = store, 0 = load
// - op_ptr_sel   in   $clog2(NUM_PTRS) pointer used as address
// - op_ptr_mode  in   2                00 direct, 01 post-inc, 10 pre-dec, 11 direct
// - op_wdata     in   DATA_W           store data
// - op_tag       in   TAG_W            load destination tag
// - ptr_wr_en    in   1                write-back load of a pointer
// - ptr_wr_sel   in   $clog2(NUM_PTRS) pointer index written
// - ptr_wr_data  in   ADDR_W           pointer value written
// - stall        out  1                hold EX/MEM and earlier stages
// - ld_valid     out  1                one-cycle pulse: ld_data/ld_tag valid
// - ld_data      out  DATA_W           load result
// - ld_tag       out  TAG_W            load destination tag
// - bus_err      out  1                one-cycle pulse on timeout abort
// - mem_req      out  1                memory request
// - mem_we       out  1                1 = write
// - mem_addr     out  ADDR_W           memory address
// - mem_wdata    out  DATA_W           memory write data
// - mem_ack      in   1                memory completion, one cycle
// - mem_rdata    in   DATA_W           read data, valid with mem_ack
// - ptr_out      out  NUM_PTRS*ADDR_W  all pointers, index 0 in LSBs
// BEHAVIOUR
// - Reset: state IDLE; every output 0 except ptr_out; pointers 0, stack pointer STK_RESET.
// - Reset mid-access drops mem_req immediately and loses the operation. No ld_valid or bus_err pulse is issued.
// - FSM has two states: IDLE and BUSY. All outputs are registered except stall.
// - stall = (state==BUSY).
// - IDLE & op_valid: accept the op and go to BUSY.
//   - Effective address: base = pointer[op_ptr_sel], bypassed by ptr_wr_data when ptr_wr_en and ptr_wr_sel==op_ptr_sel.
//   - addr = base-1 for pre-dec, otherwise base.
//   - Next cycle: mem_req=1, mem_addr=addr, mem_we=op_store, mem_wdata=op_wdata; op_tag is latched.
// - BUSY: mem_req, mem_addr, mem_we and mem_wdata hold stable until mem_ack.
//   - On mem_ack: mem_req=0 next cycle and return to IDLE.
//   - Pointer update: post-inc writes addr+1; pre-dec writes addr; direct writes nothing.
//   - If the op is a load, ld_valid=1 for one cycle with ld_data=mem_rdata and the latched tag.
// - Latency: an op accepted at cycle 0 drives mem_req at cycle 1. With ack at cycle k, ld_valid is at k+1 and stall clears at k+1.
// - A new op may be accepted in the same cycle that ld_valid pulses.
// - Timeout: the cycle counter resets on entering BUSY. If TIMEOUT BUSY cycles pass without mem_ack:
//   - drop mem_req, pulse bus_err, return to IDLE;
//   - no pointer update and no ld_valid.
// - mem_ack received in IDLE is ignored.
// - Address arithmetic is modulo 2^ADDR_W: 0 pre-dec gives all-ones; all-ones post-inc gives 0.
// - ptr_wr_en writes in any state.
// - If ptr_wr_en and a completion update hit the same pointer in the same cycle, the completion update wins (younger op).
// STRUCTURE
// - Package mem_access_pkg: PTR_DIRECT/PTR_POSTINC/PTR_PREDEC localparams and the IDLE/BUSY state encoding.
// - Sub-module mem_ptr_file: NUM_PTRS registers with two write ports (write-back, completion) under the fixed priority above, bypassed read, and flat ptr_out.
// - The FSM, timeout counter and handshake registers stay in mem_access_unit.
// TESTING
// - Load, ptr0=0x1000, post-inc, ack on the 3rd BUSY cycle, rdata=0x5A -> mem_addr=0x1000; ld_valid at ack+1 with 0x5A and tag; ptr0=0x1001.
// - Store, pre-dec on SP=0xFFFF, wdata=0x33, immediate ack -> mem_addr=0xFFFE, mem_we=1; SP=0xFFFE; no ld_valid.
// - ptr_wr_en to ptr1=0x2000 in the same cycle a load uses ptr1 -> mem_addr=0x2000 (bypass).
// - Same-cycle WB write and completion update to ptr2 -> ptr2 = completion value.
// - No ack, TIMEOUT=4 -> mem_req for 4 cycles; bus_err pulse; pointer unchanged; stall low afterwards.
// - Post-inc at 0xFFFF wraps pointer to 0x0000; nreset low while BUSY -> mem_req=0 at once and pointers at reset values.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: pointer addressing modes
// and the engine state encoding.
package mem_access_pkg;

    // Pointer addressing modes carried on op_ptr_mode_i (2'b11 behaves as direct)
    localparam logic [1:0] PTR_DIRECT  = 2'b00;
    localparam logic [1:0] PTR_POSTINC = 2'b01;
    localparam logic [1:0] PTR_PREDEC  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_ptr_file.sv
// Pointer register file: write-back port and completion port (completion has
// priority, being the younger op), combinational read with write-back bypass,
// and every pointer flattened onto one bus (index 0 in the LSBs).
module mem_ptr_file
    import mem_access_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                NUM_PTRS  = 4,
    parameter logic [ADDR_W-1:0] STK_RESET = {ADDR_W{1'b1}},
    localparam int               SEL_W     = (NUM_PTRS > 1) ? $clog2(NUM_PTRS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_en_i,
    input  logic [SEL_W-1:0]           wb_sel_i,
    input  logic [ADDR_W-1:0]          wb_data_i,
    input  logic                       cpl_en_i,
    input  logic [SEL_W-1:0]           cpl_sel_i,
    input  logic [ADDR_W-1:0]          cpl_data_i,
    input  logic [SEL_W-1:0]           rd_sel_i,
    output logic [ADDR_W-1:0]          rd_data_o,
    output logic [NUM_PTRS*ADDR_W-1:0] ptr_flat_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PTRS; gi++) begin : g_ptr
            // The top index is the stack pointer and comes out of reset at STK_RESET
            localparam logic [ADDR_W-1:0] RST_VAL = (gi == NUM_PTRS - 1) ? STK_RESET : '0;
            logic [ADDR_W-1:0] ptr_q;

            // One pointer register; completion update overrides a same-cycle write-back
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= RST_VAL;
                end else if (cpl_en_i && (cpl_sel_i == SEL_W'(gi))) begin
                    ptr_q <= cpl_data_i;
                end else if (wb_en_i && (wb_sel_i == SEL_W'(gi))) begin
                    ptr_q <= wb_data_i;
                end
            end

            assign ptr_flat_o[gi*ADDR_W +: ADDR_W] = ptr_q;
        end
    endgenerate

    // Read port sees a write-back landing this cycle so the op uses the newest value
    always_comb begin
        rd_data_o = ptr_flat_o[int'(rd_sel_i)*ADDR_W +: ADDR_W];
        if (wb_en_i && (wb_sel_i == rd_sel_i)) begin
            rd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: accepts one op from EX/MEM, runs a req/ack
// handshake with a wait-state memory, updates the addressing pointer on
// completion and aborts with bus_err if the memory never answers.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 16,
    parameter int                NUM_PTRS  = 4,
    parameter int                TAG_W     = 5,
    parameter int                TIMEOUT   = 255,
    parameter logic [ADDR_W-1:0] STK_RESET = {ADDR_W{1'b1}},
    localparam int               SEL_W     = (NUM_PTRS > 1) ? $clog2(NUM_PTRS) : 1,
    localparam int               CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid_i,
    input  logic                       op_store_i,
    input  logic [SEL_W-1:0]           op_ptr_sel_i,
    input  logic [1:0]                 op_ptr_mode_i,
    input  logic [DATA_W-1:0]          op_wdata_i,
    input  logic [TAG_W-1:0]           op_tag_i,
    input  logic                       ptr_wr_en_i,
    input  logic [SEL_W-1:0]           ptr_wr_sel_i,
    input  logic [ADDR_W-1:0]          ptr_wr_data_i,
    output logic                       stall_o,
    output logic                       ld_valid_o,
    output logic [DATA_W-1:0]          ld_data_o,
    output logic [TAG_W-1:0]           ld_tag_o,
    output logic                       bus_err_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic                       mem_ack_i,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic [NUM_PTRS*ADDR_W-1:0] ptr_out_o
);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [SEL_W-1:0]  sel_q;
    logic [1:0]        mode_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              ld_valid_q;
    logic [DATA_W-1:0] ld_data_q;
    logic [TAG_W-1:0]  ld_tag_q;
    logic              bus_err_q;

    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] eff_addr_d;
    logic              cpl_en_d;
    logic [ADDR_W-1:0] cpl_data_d;

    mem_ptr_file #(
        .ADDR_W    (ADDR_W),
        .NUM_PTRS  (NUM_PTRS),
        .STK_RESET (STK_RESET)
    ) u_ptr_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_en_i    (ptr_wr_en_i),
        .wb_sel_i   (ptr_wr_sel_i),
        .wb_data_i  (ptr_wr_data_i),
        .cpl_en_i   (cpl_en_d),
        .cpl_sel_i  (sel_q),
        .cpl_data_i (cpl_data_d),
        .rd_sel_i   (op_ptr_sel_i),
        .rd_data_o  (base_addr),
        .ptr_flat_o (ptr_out_o)
    );

    // Effective address of the incoming op and the pointer write on completion
    always_comb begin
        eff_addr_d = (op_ptr_mode_i == PTR_PREDEC) ? base_addr - ADDR_W'(1) : base_addr;
        cpl_en_d   = (state_q == ST_BUSY) && mem_ack_i &&
                     ((mode_q == PTR_POSTINC) || (mode_q == PTR_PREDEC));
        cpl_data_d = (mode_q == PTR_POSTINC) ? mem_addr_q + ADDR_W'(1) : mem_addr_q;
    end

    // Engine FSM with its registered bus and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            sel_q       <= '0;
            mode_q      <= PTR_DIRECT;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_tag_q    <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid_i) begin
                        state_q     <= ST_BUSY;
                        cnt_q       <= '0;
                        tag_q       <= op_tag_i;
                        sel_q       <= op_ptr_sel_i;
                        mode_q      <= op_ptr_mode_i;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= op_store_i;
                        mem_addr_q  <= eff_addr_d;
                        mem_wdata_q <= op_wdata_i;
                    end
                end
                ST_BUSY: begin
                    // An ack in the final allowed cycle still completes normally
                    if (mem_ack_i) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            ld_valid_q <= 1'b1;
                            ld_data_q  <= mem_rdata_i;
                            ld_tag_q   <= tag_q;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_o     = (state_q == ST_BUSY);
    assign ld_valid_o  = ld_valid_q;
    assign ld_data_o   = ld_data_q;
    assign ld_tag_o    = ld_tag_q;
    assign bus_err_o   = bus_err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the stimulus process drives ops and
// the memory side, predicts responses with a pointer-array model and queues
// them; a monitor process checks each request, load result and bus error.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid_i = 1'b0, op_store_i = 1'b0;
    logic [1:0]  op_ptr_sel_i = '0, op_ptr_mode_i = '0;
    logic [7:0]  op_wdata_i = '0;
    logic [4:0]  op_tag_i = '0;
    logic        ptr_wr_en_i = 1'b0;
    logic [1:0]  ptr_wr_sel_i = '0;
    logic [15:0] ptr_wr_data_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_rdata_i = '0;
    logic        stall_o, ld_valid_o, bus_err_o, mem_req_o, mem_we_o;
    logic [7:0]  ld_data_o, mem_wdata_o;
    logic [4:0]  ld_tag_o;
    logic [15:0] mem_addr_o;
    logic [63:0] ptr_out_o;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid_i(op_valid_i), .op_store_i(op_store_i), .op_ptr_sel_i(op_ptr_sel_i),
        .op_ptr_mode_i(op_ptr_mode_i), .op_wdata_i(op_wdata_i), .op_tag_i(op_tag_i),
        .ptr_wr_en_i(ptr_wr_en_i), .ptr_wr_sel_i(ptr_wr_sel_i), .ptr_wr_data_i(ptr_wr_data_i),
        .stall_o(stall_o), .ld_valid_o(ld_valid_o), .ld_data_o(ld_data_o), .ld_tag_o(ld_tag_o),
        .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .ptr_out_o(ptr_out_o)
    );

    typedef struct { logic [15:0] addr; logic we; logic [7:0] wd; int cyc; } req_t;
    typedef struct { logic [7:0] data; logic [4:0] tag; int cyc; } ld_t;

    req_t        req_q[$];
    ld_t         ld_q[$];
    int          err_q[$];
    logic [15:0] ptr_m[4];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [63:0] ptr_flat();
        return {ptr_m[3], ptr_m[2], ptr_m[1], ptr_m[0]};
    endfunction

    task automatic model_reset();
        ptr_m[0] = 16'h0000; ptr_m[1] = 16'h0000; ptr_m[2] = 16'h0000; ptr_m[3] = 16'hFFFF;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Idle cycle with an optional write-back and optional stray ack
    task automatic idle(input bit wb, input int sel, input logic [15:0] data, input bit stray_ack);
        ptr_wr_en_i = wb; ptr_wr_sel_i = 2'(sel); ptr_wr_data_i = data;
        mem_ack_i = stray_ack; mem_rdata_i = 8'(data);
        if (wb) ptr_m[sel] = data;
        next_cycle();
        ptr_wr_en_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    // One complete op. d = BUSY cycle carrying the ack; d > TO means no ack.
    // The c* arguments describe a write-back issued in the ack/abort cycle.
    task automatic do_op(input bit st, input int sel, input int mode, input logic [7:0] wd,
                         input logic [4:0] tag, input bit wb, input int wb_sel,
                         input logic [15:0] wb_data, input int d, input logic [7:0] rd,
                         input bit cwb, input int cwb_sel, input logic [15:0] cwb_data);
        logic [15:0] base, addr;
        int c0, ack_cyc;
        bit acked;
        acked = (d <= TO);
        base = (wb && wb_sel == sel) ? wb_data : ptr_m[sel];
        if (wb) ptr_m[wb_sel] = wb_data;
        addr = (mode == 2) ? base - 16'd1 : base;
        c0 = cyc;
        req_q.push_back('{addr, st, wd, c0 + 1});
        op_valid_i = 1'b1; op_store_i = st; op_ptr_sel_i = 2'(sel); op_ptr_mode_i = 2'(mode);
        op_wdata_i = wd; op_tag_i = tag;
        ptr_wr_en_i = wb; ptr_wr_sel_i = 2'(wb_sel); ptr_wr_data_i = wb_data;
        next_cycle();
        op_valid_i = 1'b0; ptr_wr_en_i = 1'b0;
        check("stall_busy", 64'(stall_o), 64'd1);
        repeat ((acked ? d : TO) - 1) next_cycle();
        ack_cyc = cyc;
        if (cwb) ptr_m[cwb_sel] = cwb_data;
        if (acked) begin
            if (mode == 1) ptr_m[sel] = addr + 16'd1;
            else if (mode == 2) ptr_m[sel] = addr;
            if (!st) ld_q.push_back('{rd, tag, ack_cyc + 1});
        end else begin
            err_q.push_back(ack_cyc + 1);
        end
        mem_ack_i = acked; mem_rdata_i = rd;
        ptr_wr_en_i = cwb; ptr_wr_sel_i = 2'(cwb_sel); ptr_wr_data_i = cwb_data;
        next_cycle();
        mem_ack_i = 1'b0; ptr_wr_en_i = 1'b0;
        check("stall_done", 64'(stall_o), 64'd0);
        check("req_done", 64'(mem_req_o), 64'd0);
        check("ptr_out", ptr_out_o, ptr_flat());
    endtask

    // Monitor: compare every DUT response against the scoreboard queues
    initial begin
        bit   prev_req = 1'b0;
        req_t r;
        ld_t  l;
        int   e;
        logic [24:0] held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (mem_req_o && !prev_req) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 64'd1, 64'd0);
                    end else begin
                        r = req_q.pop_front();
                        check("req_addr", 64'(mem_addr_o), 64'(r.addr));
                        check("req_we", 64'(mem_we_o), 64'(r.we));
                        check("req_wdata", 64'(mem_wdata_o), 64'(r.wd));
                        check("req_cycle", 64'(cyc), 64'(r.cyc));
                    end
                    held = {mem_addr_o, mem_we_o, mem_wdata_o};
                end else if (mem_req_o) begin
                    check("req_hold", 64'({mem_addr_o, mem_we_o, mem_wdata_o}), 64'(held));
                end
                prev_req = mem_req_o;
                if (ld_valid_o) begin
                    if (ld_q.size() == 0) begin
                        check("unexpected_ld", 64'd1, 64'd0);
                    end else begin
                        l = ld_q.pop_front();
                        check("ld_data", 64'(ld_data_o), 64'(l.data));
                        check("ld_tag", 64'(ld_tag_o), 64'(l.tag));
                        check("ld_cycle", 64'(cyc), 64'(l.cyc));
                    end
                end
                if (bus_err_o) begin
                    if (err_q.size() == 0) begin
                        check("unexpected_err", 64'd1, 64'd0);
                    end else begin
                        e = err_q.pop_front();
                        check("err_cycle", 64'(cyc), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();
        check("rst_ptr_out", ptr_out_o, ptr_flat());
        check("rst_outputs", 64'({stall_o, ld_valid_o, bus_err_o, mem_req_o, mem_we_o}), 64'd0);
        check("rst_data", 64'({ld_data_o, ld_tag_o, mem_addr_o, mem_wdata_o}), 64'd0);

        // Load, post-inc on ptr0=0x1000, ack on 3rd BUSY cycle
        idle(1'b1, 0, 16'h1000, 1'b0);
        do_op(1'b0, 0, 1, 8'h00, 5'd7, 1'b0, 0, 16'h0, 3, 8'h5A, 1'b0, 0, 16'h0);
        // Store, pre-dec on SP, immediate ack
        do_op(1'b1, 3, 2, 8'h33, 5'd0, 1'b0, 0, 16'h0, 1, 8'h00, 1'b0, 0, 16'h0);
        // Write-back bypass into the addressing pointer
        do_op(1'b0, 1, 0, 8'h00, 5'd9, 1'b1, 1, 16'h2000, 2, 8'hC3, 1'b0, 0, 16'h0);
        // Write-back and completion update hit ptr2 in the same cycle
        do_op(1'b0, 2, 1, 8'h00, 5'd3, 1'b0, 0, 16'h0, 2, 8'h11, 1'b1, 2, 16'hABCD);
        // No ack: timeout abort, pointer untouched
        do_op(1'b0, 1, 1, 8'h00, 5'd4, 1'b0, 0, 16'h0, TO + 1, 8'h00, 1'b0, 0, 16'h0);
        // Wrap-around: post-inc at 0xFFFF, pre-dec at 0x0000
        idle(1'b1, 0, 16'hFFFF, 1'b1);
        do_op(1'b1, 0, 1, 8'h77, 5'd0, 1'b0, 0, 16'h0, 1, 8'h00, 1'b0, 0, 16'h0);
        do_op(1'b0, 0, 2, 8'h00, 5'd1, 1'b0, 0, 16'h0, 4, 8'hEE, 1'b0, 0, 16'h0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                idle(($urandom_range(0, 3) == 0), $urandom_range(0, 3), 16'($urandom),
                     ($urandom_range(0, 2) == 0));
            do_op(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom),
                  5'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 16'($urandom),
                  $urandom_range(1, TO + 1), 8'($urandom),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 16'($urandom));
        end

        // Reset while BUSY: request drops at once, pointers return to reset values
        idle(1'b1, 1, 16'h4321, 1'b0);
        req_q.push_back('{16'h4321, 1'b0, 8'h00, cyc + 1});
        op_valid_i = 1'b1; op_store_i = 1'b0; op_ptr_sel_i = 2'd1; op_ptr_mode_i = 2'd1;
        op_wdata_i = 8'h00; op_tag_i = 5'd2;
        next_cycle();
        op_valid_i = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_req", 64'(mem_req_o), 64'd0);
        check("rst_mid_stall", 64'(stall_o), 64'd0);
        check("rst_mid_ptr", ptr_out_o, ptr_flat());
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("rst_mid_pulses", 64'({ld_valid_o, bus_err_o}), 64'd0);
        do_op(1'b0, 3, 1, 8'h00, 5'd30, 1'b0, 0, 16'h0, 1, 8'hA5, 1'b0, 0, 16'h0);

        repeat (3) next_cycle();
        check("req_queue_empty", 64'(req_q.size()), 64'd0);
        check("ld_queue_empty", 64'(ld_q.size()), 64'd0);
        check("err_queue_empty", 64'(err_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
